vect_wb_stage: RTL

- Writeback stage directly downstream of vect_unit.
- Captures each 32-bit result and its 2-bit flags, along with the destination register index, into a small FIFO.
- Drains entries to the CPU register-file write port (Reg0..Reg31) under a ready handshake.
- Maintains last-retired flags and sticky (accumulated) flags for branch and status logic.

---
 rtl/vect_wb_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/vect_wb_stage.sv
// vect_wb_stage: writeback stage between vect_unit and the register-file write port.
// Latency: 1 cycle from push to wb_* / retire (0 cycles with VECT_WB_BYPASS_EN on an empty stage).
// Backpressure: in_ready = (count < DEPTH); wb_ready stalls write entries at the head, flags-only entries never stall.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready             - entry handshake from vect_unit
//   in_data/in_flags/in_rd/in_wen - result, flags, destination index, write-enable
//   wb_en/wb_ready                - register-file write request / accept
//   wb_addr/wb_data               - write index and data (zero when wb_en=0)
//   flags_q                       - flags of the most recently retired entry
//   sticky_flags/clr_sticky       - OR of retired flags since last clear, and its clear
//   count/busy                    - occupancy and (count != 0)
//
// Optional feature macro: VECT_WB_BYPASS_EN (zero-latency retire of entries
// arriving at an empty stage). Undefined by default.
//
// DEPTH must be a power of two and at least 2: pointers wrap by natural
// binary overflow.

module vect_wb_stage #(
  parameter int DATA_W = 32,
  parameter int FLAG_W = 2,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [FLAG_W-1:0]          in_flags,
  input  logic [ADDR_W-1:0]          in_rd,
  input  logic                       in_wen,

  output logic                       wb_en,
  input  logic                       wb_ready,
  output logic [ADDR_W-1:0]          wb_addr,
  output logic [DATA_W-1:0]          wb_data,

  output logic [FLAG_W-1:0]          flags_q,
  output logic [FLAG_W-1:0]          sticky_flags,
  input  logic                       clr_sticky,

  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] flags;
    logic [ADDR_W-1:0] rd;
    logic              wen;
  } entry_t;

  // Storage and state
  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [FLAG_W-1:0]  r_flags_q;
  logic [FLAG_W-1:0]  r_sticky;

  // Datapath / control wires
  entry_t             w_in_ent;
  entry_t             w_head;
  logic               w_head_vld;
  logic               w_fifo_pop;
  logic               w_byp_vld;
  logic               w_byp_ret;
  logic               w_push;
  logic               w_retire;
  logic [FLAG_W-1:0]  w_ret_flags;

  assign w_in_ent   = {in_data, in_flags, in_rd, in_wen};
  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_vld = (r_count != '0);

  // Ready depends only on registered occupancy, never on in_valid or
  // wb_ready, so upstream sees no combinational path through this stage.
  assign in_ready = (r_count < FULL_CNT);

  // Flags-only heads retire unconditionally; write heads wait for wb_ready.
  assign w_fifo_pop = w_head_vld && (!w_head.wen || wb_ready);

`ifdef VECT_WB_BYPASS_EN
  // An entry arriving at an empty stage is presented straight to the
  // write port. It retires without being stored when it can complete this
  // cycle (flags-only, or write accepted); otherwise it is pushed normally.
  assign w_byp_vld = !w_head_vld && in_valid;
  assign w_byp_ret = w_byp_vld && (!in_wen || wb_ready);
`else
  assign w_byp_vld = 1'b0;
  assign w_byp_ret = 1'b0;
`endif

  assign w_push = in_valid && in_ready && !w_byp_ret;

  // Queue pop and bypass retire are mutually exclusive: bypass needs an
  // empty queue, pop needs a valid head.
  assign w_retire    = w_fifo_pop || w_byp_ret;
  assign w_ret_flags = w_fifo_pop ? w_head.flags : in_flags;

  // Write port drive. Address and data are forced to zero when idle so the
  // register file never sees stale storage contents.
  always_comb begin
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    if (w_head_vld && w_head.wen) begin
      wb_en   = 1'b1;
      wb_addr = w_head.rd;
      wb_data = w_head.data;
    end else if (w_byp_vld && in_wen) begin
      wb_en   = 1'b1;
      wb_addr = in_rd;
      wb_data = in_data;
    end
  end

  // Storage has no reset; entries are only observed while count covers them.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= w_in_ent;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_fifo_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Retired-flag tracking. A retiring entry's flags are OR'd in after the
  // clear is applied, so a set in the same cycle survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags_q <= '0;
      r_sticky  <= '0;
    end else begin
      if (w_retire) begin
        r_flags_q <= w_ret_flags;
        r_sticky  <= (clr_sticky ? '0 : r_sticky) | w_ret_flags;
      end else if (clr_sticky) begin
        r_sticky  <= '0;
      end
    end
  end

  assign flags_q      = r_flags_q;
  assign sticky_flags = r_sticky;
  assign count        = r_count;
  assign busy         = w_head_vld;

endmodule
